// File: rtl/pipe_skid_stage.sv
// Generic inter-stage pipeline register: valid/ready handshakes on both sides,
// two-entry skid buffer so in_ready is registered, plus stall/bubble controls.
`ifndef CTRL_Wire_Bus
`define CTRL_Wire_Bus 1:0
`endif
`ifndef CTRL_STATE_Default
`define CTRL_STATE_Default 2'b00
`endif
`ifndef CTRL_STATE_Stalled
`define CTRL_STATE_Stalled 2'b01
`endif
`ifndef CTRL_STATE_Bubble
`define CTRL_STATE_Bubble 2'b10
`endif

module pipe_skid_stage #(
   parameter int unsigned       DATA_W     = 64,
   parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
   parameter int unsigned       CNT_W      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [`CTRL_Wire_Bus] ctrl_signal_i,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     out_data,
   output logic [1:0]            count_o,
   output logic [CNT_W-1:0]      drop_cnt_o
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   main_q, main_d;
   logic [DATA_W-1:0]   skid_q, skid_d;
   logic [CNT_W-1:0]    drop_q, drop_d;

   logic                ctrl_default_s;
   logic                ctrl_bubble_s;
   logic                push_s;
   logic                pop_s;
   logic [1:0]          occupancy_s;
   logic [CNT_W:0]      drop_sum_s;

   // Unknown control encodings fall through to the stalled behaviour.
   assign ctrl_default_s = (ctrl_signal_i == `CTRL_STATE_Default);
   assign ctrl_bubble_s  = (ctrl_signal_i == `CTRL_STATE_Bubble);
   assign occupancy_s    = state_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         drop_q  <= {CNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         drop_q  <= drop_d;
      end
   end

   // Payload storage is never cleared; only the state decides validity.
   always_ff @(posedge clk) begin
      main_q <= main_d;
      skid_q <= skid_d;
   end

   always_comb begin
      state_d    = state_q;
      main_d     = main_q;
      skid_d     = skid_q;
      drop_d     = drop_q;
      drop_sum_s = {1'b0, drop_q} + {{(CNT_W-1){1'b0}}, occupancy_s};
      if (ctrl_bubble_s) begin
         state_d = ST_EMPTY;
         if (drop_sum_s[CNT_W]) begin
            drop_d = {CNT_W{1'b1}};
         end else begin
            drop_d = drop_sum_s[CNT_W-1:0];
         end
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (push_s) begin
                  state_d = ST_ONE;
                  main_d  = in_data;
               end else begin
                  state_d = ST_EMPTY;
               end
            end
            ST_ONE: begin
               if (push_s && pop_s) begin
                  main_d = in_data;
               end else if (push_s) begin
                  state_d = ST_FULL;
                  skid_d  = in_data;
               end else if (pop_s) begin
                  state_d = ST_EMPTY;
               end else begin
                  state_d = ST_ONE;
               end
            end
            ST_FULL: begin
               if (pop_s) begin
                  state_d = ST_ONE;
                  main_d  = skid_q;
               end else begin
                  state_d = ST_FULL;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
   end

   always_comb begin
      in_ready   = (state_q != ST_FULL) && ctrl_default_s;
      out_valid  = (state_q != ST_EMPTY) && !ctrl_bubble_s;
      push_s     = in_valid && in_ready;
      pop_s      = out_valid && out_ready;
      count_o    = occupancy_s;
      drop_cnt_o = drop_q;
      if (out_valid) begin
         out_data = main_q;
      end else begin
         out_data = BUBBLE_VAL;
      end
   end

endmodule
